uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
Parametrised successor to the fixed 8-byte UART word dumper. It latches a multi-byte word through a valid/ready handshake and serialises a programmable number of its bytes as standard 8N1/8N2 UART frames. Byte order, stop bits and inter-byte gap are configurable, and completion is signalled with a done pulse. It sits between measurement/readout logic and the board UART pin.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); honoured everywhere, never hard-coded; must be >= 2
NUM_BYTES, 8, bytes in s_data; must be >= 1
MSB_FIRST, 1, 1: send s_data[8*NUM_BYTES-1 -: 8] first; 0: send s_data[7:0] first
STOP_BITS, 1, 1 or 2 stop bits per frame
GAP_CLKS, 0, idle-high clk cycles inserted between bytes of one word (not after the last byte)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_data  in  8*NUM_BYTES  word to transmit
s_len  in  $clog2(NUM_BYTES+1)  number of bytes to send
s_valid  in  1  request
s_ready  out  1  block idle and able to accept
busy  out  1  word in progress (accepted, not yet done)
done  out  1  one-cycle pulse when the word is finished
byte_idx  out  $clog2(NUM_BYTES+1)  bytes fully sent in current word
tx  out  1  UART serial line, idle high

Behaviour:
- Reset values: tx=1, s_ready=1, busy=0, done=0, byte_idx=0, FSM=IDLE. Reset mid-frame aborts; tx=1 on the cycle after rst is sampled; no done pulse.
- Handshake: transfer occurs on a clk edge with s_valid & s_ready. s_data and s_len are registered into a shift register and length counter; inputs may change afterwards. s_ready=1 only in IDLE.
- s_len clamp: values > NUM_BYTES are treated as NUM_BYTES. s_len=0 is accepted; done pulses on the next cycle, tx stays 1, busy stays 0.
- The first s_len bytes in transmit order are sent, per MSB_FIRST. Bits within a byte are always sent LSB first.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE -> START on accept with len>0.
  - START holds tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA holds 8 bits of CLKS_PER_BIT cycles each, then -> STOP.
  - STOP holds tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At STOP end, byte_idx increments. If bytes remain: -> GAP when GAP_CLKS>0, else -> START. Otherwise -> IDLE.
  - GAP holds tx=1 for GAP_CLKS cycles, then -> START.
- Latency: tx falls on the first cycle after the accept edge.
- Word duration from first start-bit cycle to return to IDLE: L*(9+STOP_BITS)*CLKS_PER_BIT + (L-1)*GAP_CLKS cycles, where L is the clamped s_len.
- done: asserted for exactly one cycle, the first IDLE cycle after the final stop bit. s_ready=1 in that same cycle, so back-to-back words are possible with 1 idle-high cycle between them.
- busy = FSM != IDLE. byte_idx holds its final value until the next accept, then clears to 0.
- Counters: bit-time counter is $clog2(CLKS_PER_BIT) wide and wraps at CLKS_PER_BIT-1. Bit counter is 3 bits. Byte counter is compared against the clamped length; no out-of-range byte is ever selected (prior design's 4'h0 fallthrough is not replicated).
- s_valid held during busy is ignored, not queued.

Decomposition:
- Package uart_pkg: FSM state enum, UART_DATA_BITS=8, helper function for bit-counter width.
- One sub-module uart_bit_tx: single-byte start/data/stop serialiser with i_start/i_byte/o_done. It is parameterised by CLKS_PER_BIT and STOP_BITS.
- uart_word_tx owns the handshake, byte sequencing, gap timer and length clamp.

Test Plan:
1. CLKS_PER_BIT=4, NUM_BYTES=4, MSB_FIRST=1. Send s_data=0xA1B2C3D4, s_len=4 -> decoded bytes A1,B2,C3,D4. Frame = 4*10*4 = 160 cycles. done pulses once. byte_idx ends at 4.
2. Same config with MSB_FIRST=0, s_len=2, s_data=0x11223344 -> bytes 44,33 only. done at 80 cycles + 1.
3. s_len=0 -> accept; done next cycle; tx never low. s_len=7 with NUM_BYTES=4 -> exactly 4 bytes sent.
4. STOP_BITS=2, GAP_CLKS=5, s_len=3 -> stop high for 8 cycles. 5 extra idle cycles between bytes, none after the last. Total 3*44+2*5 = 142 cycles.
5. Hold s_valid high continuously with new data each accept -> consecutive words separated by exactly 1 idle cycle. s_ready low throughout busy. Mid-word s_data changes do not alter output.
6. Assert rst during DATA of byte 2 -> tx=1 next cycle, s_ready=1, busy=0, done=0, byte_idx=0. A subsequent word transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter and its byte serialiser.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } uart_state_e;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_SEND,
    WS_GAP
  } word_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_tx.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, 1 or 2 stop bits.
module uart_bit_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_done,
  output logic       o_tx
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (clk_cnt_q == CNT_LAST);

  // A start request in the final stop cycle chains straight into the next start bit.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    o_done     = 1'b0;
    if (state_q != ST_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_START;
          shift_d   = i_byte;
          clk_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            o_done = 1'b1;
            if (i_start) begin
              state_d = ST_START;
              shift_d = i_byte;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign o_tx = tx_q;

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART word transmitter: valid/ready word capture, byte sequencing,
// inter-byte gap timing and length clamping around a single-byte serialiser.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_BYTES    = 8,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [8*NUM_BYTES-1:0]             s_data,
  input  logic [$clog2(NUM_BYTES+1)-1:0]     s_len,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_idx,
  output logic                               tx
);

  localparam int LW = $clog2(NUM_BYTES + 1);
  localparam int DW = UART_DATA_BITS * NUM_BYTES;
  localparam int GW = cnt_width(GAP_CLKS);
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_BYTES);

  function automatic logic [7:0] head_byte(input logic [DW-1:0] w);
    return (MSB_FIRST != 0) ? w[DW-1 -: 8] : w[7:0];
  endfunction

  function automatic logic [DW-1:0] drop_byte(input logic [DW-1:0] w);
    return (MSB_FIRST != 0) ? (w << 8) : (w >> 8);
  endfunction

  word_state_e   state_q, state_d;
  logic [DW-1:0] word_q, word_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] byte_idx_q, byte_idx_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          done_q, done_d;
  logic [LW-1:0] len_clamped;
  logic [LW-1:0] next_idx;
  logic          bit_start;
  logic [7:0]    bit_byte;
  logic          bit_done;

  assign len_clamped = (s_len > MAX_LEN) ? MAX_LEN : s_len;
  assign next_idx    = byte_idx_q + 1'b1;

  // The first byte is taken straight from s_data so tx can fall on the cycle after accept;
  // word_q always holds the not-yet-sent bytes with the next one at its head.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    bit_start  = 1'b0;
    bit_byte   = head_byte(word_q);
    case (state_q)
      WS_IDLE: begin
        if (s_valid) begin
          word_d     = drop_byte(s_data);
          len_d      = len_clamped;
          byte_idx_d = '0;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            bit_start = 1'b1;
            bit_byte  = head_byte(s_data);
            state_d   = WS_SEND;
          end
        end
      end
      WS_SEND: begin
        if (bit_done) begin
          byte_idx_d = next_idx;
          if (next_idx < len_q) begin
            if (GAP_CLKS > 0) begin
              state_d   = WS_GAP;
              gap_cnt_d = '0;
            end else begin
              bit_start = 1'b1;
              word_d    = drop_byte(word_q);
            end
          end else begin
            state_d = WS_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WS_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (int'(gap_cnt_q) == GAP_CLKS - 1) begin
          bit_start = 1'b1;
          word_d    = drop_byte(word_q);
          state_d   = WS_SEND;
        end
      end
      default: state_d = WS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WS_IDLE;
      word_q     <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
    end
  end

  uart_bit_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_bit_tx (
    .clk     (clk),
    .rst     (rst),
    .i_start (bit_start),
    .i_byte  (bit_byte),
    .o_done  (bit_done),
    .o_tx    (tx)
  );

  assign s_ready  = (state_q == WS_IDLE);
  assign busy     = (state_q != WS_IDLE);
  assign done     = done_q;
  assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: three configurations (MSB first, LSB first,
// two stop bits with inter-byte gap) share one clock and reset.
module tb_uart_word_tx;

  localparam int C    = 4;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data   [NDUT];
  logic [2:0]  s_len    [NDUT];
  logic        s_valid  [NDUT];
  logic        s_ready  [NDUT];
  logic        busy     [NDUT];
  logic        done     [NDUT];
  logic        tx       [NDUT];
  logic [2:0]  byte_idx [NDUT];

  int checks   = 0;
  int failures = 0;

  logic       cap_tx[$];
  logic       cap_done[$];
  logic       cap_ready[$];
  logic       cap_busy[$];
  logic [2:0] cap_idx[$];
  logic       exp_tx[$];

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(4), .MSB_FIRST(1), .STOP_BITS(1), .GAP_CLKS(0)) dut_msb (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_len(s_len[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .busy(busy[0]), .done(done[0]), .byte_idx(byte_idx[0]), .tx(tx[0]));

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(4), .MSB_FIRST(0), .STOP_BITS(1), .GAP_CLKS(0)) dut_lsb (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_len(s_len[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .busy(busy[1]), .done(done[1]), .byte_idx(byte_idx[1]), .tx(tx[1]));

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(4), .MSB_FIRST(1), .STOP_BITS(2), .GAP_CLKS(5)) dut_gap (
    .clk(clk), .rst(rst), .s_data(s_data[2]), .s_len(s_len[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .busy(busy[2]), .done(done[2]), .byte_idx(byte_idx[2]), .tx(tx[2]));

  always #5 clk = ~clk;

  function automatic int stopBits(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction

  function automatic int gapClks(input int sel);
    return (sel == 2) ? 5 : 0;
  endfunction

  function automatic int frameLen(input int sel, input int n);
    return (n == 0) ? 0 : n * (9 + stopBits(sel)) * C + (n - 1) * gapClks(sel);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [31:0] data, input logic [2:0] len, input bit hold);
    s_data[sel]  = data;
    s_len[sel]   = len;
    s_valid[sel] = 1'b1;
    @(negedge clk);
    if (!hold) s_valid[sel] = 1'b0;
  endtask

  task automatic captureCycles(input int sel, input int n);
    cap_tx.delete(); cap_done.delete(); cap_ready.delete(); cap_busy.delete(); cap_idx.delete();
    for (int i = 0; i < n; i++) begin
      cap_tx.push_back(tx[sel]);
      cap_done.push_back(done[sel]);
      cap_ready.push_back(s_ready[sel]);
      cap_busy.push_back(busy[sel]);
      cap_idx.push_back(byte_idx[sel]);
      @(negedge clk);
    end
  endtask

  // exp_bytes holds the bytes in transmit order, first byte in bits 31:24.
  task automatic appendFrames(input int sel, input logic [31:0] exp_bytes, input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = exp_bytes[31 - 8*k -: 8];
      repeat (C) exp_tx.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (C) exp_tx.push_back(b[j]);
      repeat (stopBits(sel) * C) exp_tx.push_back(1'b1);
      if (k < n - 1) repeat (gapClks(sel)) exp_tx.push_back(1'b1);
    end
  endtask

  task automatic checkWave(input string tag);
    int m = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i >= cap_tx.size() || cap_tx[i] !== exp_tx[i]) m++;
    end
    checkOutput($sformatf("%s wave mismatches", tag), m, 0);
  endtask

  task automatic decodeBytes(input int sel, input int first_cycle, input logic [31:0] exp_bytes,
                             input int n, input string tag);
    logic [7:0] got;
    int off, idx;
    for (int k = 0; k < n; k++) begin
      off = first_cycle - 1 + k * ((9 + stopBits(sel)) * C + gapClks(sel));
      for (int j = 0; j < 8; j++) begin
        idx    = off + C * (1 + j) + C / 2;
        got[j] = (idx < cap_tx.size()) ? cap_tx[idx] : 1'bx;
      end
      checkOutput($sformatf("%s byte%0d", tag, k), got, exp_bytes[31 - 8*k -: 8]);
    end
  endtask

  task automatic findDone(input int from_cycle, output int at);
    at = -1;
    for (int i = from_cycle - 1; i < cap_done.size(); i++) begin
      if (cap_done[i] === 1'b1) begin
        at = i + 1;
        break;
      end
    end
  endtask

  task automatic runWord(input int sel, input logic [31:0] data, input logic [2:0] len,
                         input logic [31:0] exp_bytes, input int n, input string tag);
    int frame = frameLen(sel, n);
    int d = frame + 1;
    int at, ndone, nbusy, nready;
    checkOutput($sformatf("%s ready before accept", tag), s_ready[sel], 1);
    applyStimulus(sel, data, len, 1'b0);
    s_data[sel] = ~data;
    captureCycles(sel, d + 2);
    exp_tx.delete();
    appendFrames(sel, exp_bytes, n);
    while (exp_tx.size() < d + 2) exp_tx.push_back(1'b1);
    checkWave(tag);
    findDone(1, at);
    checkOutput($sformatf("%s done cycle", tag), at, d);
    ndone = 0; nbusy = 0; nready = 0;
    for (int i = 0; i < cap_done.size(); i++) begin
      ndone  += (cap_done[i] === 1'b1) ? 1 : 0;
      nbusy  += (cap_busy[i] === 1'b1) ? 1 : 0;
      nready += (cap_ready[i] === 1'b1) ? 1 : 0;
    end
    checkOutput($sformatf("%s done pulses", tag), ndone, 1);
    checkOutput($sformatf("%s busy cycles", tag), nbusy, frame);
    checkOutput($sformatf("%s ready cycles", tag), nready, d + 2 - frame);
    checkOutput($sformatf("%s byte_idx final", tag), cap_idx[d - 1], n);
    decodeBytes(sel, 1, exp_bytes, n, tag);
  endtask

  initial begin
    int at, nready, ndone, nlow;
    for (int s = 0; s < NDUT; s++) begin
      s_data[s] = '0; s_len[s] = '0; s_valid[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      checkOutput($sformatf("reset tx%0d", s), tx[s], 1);
      checkOutput($sformatf("reset ready%0d", s), s_ready[s], 1);
      checkOutput($sformatf("reset busy%0d", s), busy[s], 0);
      checkOutput($sformatf("reset done%0d", s), done[s], 0);
      checkOutput($sformatf("reset idx%0d", s), byte_idx[s], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    runWord(0, 32'hA1B2C3D4, 3'd4, 32'hA1B2C3D4, 4, "msb4");
    runWord(1, 32'h11223344, 3'd2, 32'h44330000, 2, "lsb2");
    runWord(0, 32'hDEADBEEF, 3'd0, 32'h00000000, 0, "len0");
    runWord(0, 32'h01020304, 3'd7, 32'h01020304, 4, "clamp7");
    runWord(2, 32'hDEADBEEF, 3'd3, 32'hDEADBE00, 3, "gap3");

    // Back-to-back words with s_valid held and data changing mid-word.
    applyStimulus(0, 32'h5A000000, 3'd1, 1'b1);
    s_data[0] = 32'h3C000000;
    cap_tx.delete(); cap_done.delete(); cap_ready.delete(); cap_busy.delete(); cap_idx.delete();
    for (int i = 1; i <= 84; i++) begin
      cap_tx.push_back(tx[0]);
      cap_done.push_back(done[0]);
      cap_ready.push_back(s_ready[0]);
      cap_busy.push_back(busy[0]);
      cap_idx.push_back(byte_idx[0]);
      if (i == 45) s_data[0] = 32'hFF000000;
      if (i == 81) s_valid[0] = 1'b0;
      @(negedge clk);
    end
    exp_tx.delete();
    appendFrames(0, 32'h5A000000, 1);
    exp_tx.push_back(1'b1);
    appendFrames(0, 32'h3C000000, 1);
    repeat (3) exp_tx.push_back(1'b1);
    checkWave("b2b");
    findDone(1, at);
    checkOutput("b2b done1 cycle", at, 41);
    findDone(42, at);
    checkOutput("b2b done2 cycle", at, 82);
    checkOutput("b2b tx after idle", cap_tx[41], 0);
    nready = 0;
    for (int i = 0; i < 81; i++) if (i != 40) nready += (cap_ready[i] === 1'b1) ? 1 : 0;
    checkOutput("b2b ready while busy", nready, 0);
    decodeBytes(0, 1, 32'h5A000000, 1, "b2b w1");
    decodeBytes(0, 42, 32'h3C000000, 1, "b2b w2");

    // Reset during a zero data bit of the second byte.
    applyStimulus(0, 32'hA1B2C3D4, 3'd4, 1'b0);
    repeat (53) @(negedge clk);
    checkOutput("rst pre tx", tx[0], 0);
    checkOutput("rst pre idx", byte_idx[0], 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst tx", tx[0], 1);
    checkOutput("rst ready", s_ready[0], 1);
    checkOutput("rst busy", busy[0], 0);
    checkOutput("rst done", done[0], 0);
    checkOutput("rst idx", byte_idx[0], 0);
    rst = 1'b0;
    captureCycles(0, 10);
    ndone = 0; nlow = 0;
    for (int i = 0; i < 10; i++) begin
      ndone += (cap_done[i] === 1'b1) ? 1 : 0;
      nlow  += (cap_tx[i] !== 1'b1) ? 1 : 0;
    end
    checkOutput("rst no done", ndone, 0);
    checkOutput("rst tx idle", nlow, 0);
    runWord(0, 32'h0F00FF00, 3'd2, 32'h0F000000, 2, "post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
